booth_mac_accum: RTL and testbench

// - Sequencing and accumulate stage around the Booth multiplier datapath/controller pair.
// - Accepts operand pairs over a valid/ready stream and issues each pair to the multiplier (start pulse).
// - Consumes each 2W-bit product on done and sums the products into a signed ACC_W accumulator.
// - Presents the total on a valid/ready result port after the operand flagged last.

---
 rtl/booth_mac_accum.sv | 122 ++++++++++++
 tb/tb_booth_mac_accum.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_accum.sv
// booth_mac_accum: feeds operand pairs to a Booth multiplier and sums the products into a signed accumulator.
// Define BOOTH_MAC_TIMEOUT_EN to abandon a product after TIMEOUT WAIT cycles and raise err.
module booth_mac_accum #(
    parameter int W       = 16,
    parameter int ACC_W   = 40,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_last,
    output logic               mul_start,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic               mul_done,
    input  logic [2*W-1:0]     mul_prod,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic [ACC_W-1:0]   acc_data,
    output logic [CNT_W-1:0]   acc_count,
    output logic               ovf,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, HOLD} state_t;
    state_t state;
    logic [W-1:0] a_r, b_r;
    logic last_r, first;
    logic [2*W-1:0] prod_r;
    logic [ACC_W-1:0] acc, pext, sum;
    logic [CNT_W-1:0] cnt;
`ifdef BOOTH_MAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;
`endif
    if (ACC_W < 2*W || TIMEOUT < 1) begin : g_bad_params
        $error("booth_mac_accum: ACC_W must be >= 2*W and TIMEOUT >= 1");
    end
    assign pext      = ACC_W'($signed(prod_r));
    assign sum       = acc + pext;
    assign mul_a     = a_r;
    assign mul_b     = b_r;
    assign acc_data  = acc;
    assign acc_count = cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            mul_start <= 1'b0;
            acc_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            last_r    <= 1'b0;
            first     <= 1'b0;
            prod_r    <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
`ifdef BOOTH_MAC_TIMEOUT_EN
            wcnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r       <= in_a;
                    b_r       <= in_b;
                    last_r    <= in_last;
                    in_ready  <= 1'b0;
                    mul_start <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    first     <= 1'b1;
                    state     <= WAIT;
`ifdef BOOTH_MAC_TIMEOUT_EN
                    wcnt      <= '0;
`endif
                end
                WAIT: begin
                    first <= 1'b0;
                    // done seen in the first WAIT cycle is the previous operation's stale level
                    if (mul_done && !first) begin
                        prod_r <= mul_prod;
                        state  <= ACC;
                    end
`ifdef BOOTH_MAC_TIMEOUT_EN
                    else if (wcnt == TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        acc_valid <= last_r;
                        in_ready  <= !last_r;
                        state     <= last_r ? HOLD : IDLE;
                    end else
                        wcnt <= wcnt + 1'b1;
`endif
                end
                ACC: begin
                    acc       <= sum;
                    cnt       <= &cnt ? cnt : cnt + 1'b1;
                    ovf       <= ovf | ((acc[ACC_W-1] == pext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]));
                    acc_valid <= last_r;
                    in_ready  <= !last_r;
                    state     <= last_r ? HOLD : IDLE;
                end
                HOLD: if (acc_ready) begin
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    err       <= 1'b0;
                    acc_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mac_accum.sv
// tb_booth_mac_accum: two instances (ACC_W=40 and ACC_W=32) share stimulus; a behavioural multiplier
// and an integer-arithmetic accumulation model supply all expected values.
module tb_booth_mac_accum;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic in_valid = 1'b0, in_last = 1'b0, acc_ready = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [1:0] ir, ms, av, ov, er;
    logic [1:0] md = '0;
    logic [1:0][15:0] ma, mb;
    logic [1:0][31:0] mp = '0, pq = '0;
    logic [1:0][7:0] cnt;
    logic [39:0] ad0;
    logic [31:0] ad1;

    booth_mac_accum #(.W(16), .ACC_W(40), .CNT_W(8), .TIMEOUT(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .mul_start(ms[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_done(md[0]),
        .mul_prod(mp[0]), .acc_valid(av[0]), .acc_ready(acc_ready), .acc_data(ad0),
        .acc_count(cnt[0]), .ovf(ov[0]), .err(er[0]));
    booth_mac_accum #(.W(16), .ACC_W(32), .CNT_W(8), .TIMEOUT(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .mul_start(ms[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_done(md[1]),
        .mul_prod(mp[1]), .acc_valid(av[1]), .acc_ready(acc_ready), .acc_data(ad1),
        .acc_count(cnt[1]), .ovf(ov[1]), .err(er[1]));

    // Behavioural multiplier: done stays high (stale) into the first WAIT cycle, drops, then rises after lat edges.
    int lat = 4;
    logic [1:0] stuck = '0;
    int bc[2] = '{0, 0};
    int starts[2] = '{0, 0};
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ms[i]) begin
                bc[i]     <= lat;
                pq[i]     <= int'($signed(ma[i])) * int'($signed(mb[i]));
                starts[i] <= starts[i] + 1;
            end else if (bc[i] > 0) begin
                bc[i] <= bc[i] - 1;
                md[i] <= (bc[i] == 1) && !stuck[i];
                if (bc[i] == 1) mp[i] <= pq[i];
            end
        end
    end

    int pass_n = 0, tot_n = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: exact integer sum, wrapped to each accumulator width.
    longint macc[2];
    int mcnt;
    logic [1:0] movf;
    function automatic longint wrapw(input longint s, input int w);
        longint m = longint'(1) << w;
        longint r = s % m;
        if (r >= m / 2) r -= m;
        else if (r < -(m / 2)) r += m;
        return r;
    endfunction
    function automatic logic [63:0] tr(input longint v, input int w);
        return v & ((64'd1 << w) - 1);
    endfunction
    task automatic model_clear();
        macc[0] = 0; macc[1] = 0; mcnt = 0; movf = '0;
    endtask
    task automatic model_add(input int a, input int b);
        longint p = longint'(a) * longint'(b);
        for (int k = 0; k < 2; k++) begin
            int w = k == 0 ? 40 : 32;
            longint s = macc[k] + p;
            longint hi = longint'(1) << (w - 1);
            if (s >= hi || s < -hi) movf[k] = 1'b1;
            macc[k] = wrapw(s, w);
        end
        mcnt++;
    endtask

    task automatic send(input int a, input int b, input bit last, input int l);
        int n = 0;
        while (!ir[0] && n < 3000) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", 64'(ir), 64'(2'b11));
        lat = l; in_a = 16'(a); in_b = 16'(b); in_last = last; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_add(a, b);
    endtask

    task automatic get_result(input string nm, input int hold, input logic [39:0] e0, input logic [31:0] e1,
                              input int ec, input logic eo0, input logic eo1, input logic ee);
        int n = 0;
        while (!av[0] && n < 3000) begin @(posedge clk); #1; n++; end
        chk({nm, "_valid"}, 64'({av, ir}), 64'(4'b1100));
        chk({nm, "_data40"}, 64'(ad0), 64'(e0));
        chk({nm, "_data32"}, 64'(ad1), 64'(e1));
        chk({nm, "_count"}, 64'(cnt), 64'({8'(ec), 8'(ec)}));
        chk({nm, "_flags"}, 64'({ov, er}), 64'({eo1, eo0, ee, ee}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold"}, {av, ir, ov, ad0, cnt[0]}, {2'b11, 2'b00, eo1, eo0, e0, 8'(ec)});
        end
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        chk({nm, "_cleared"}, {av, ir, ov, er, cnt, ad0[15:0], ad1[15:0]}, {2'b00, 2'b11, 4'b0, 48'b0});
        model_clear();
    endtask

    typedef struct {
        int a; int b; bit last; int lat;
        logic [39:0] e0; logic [31:0] e1; int ec; logic eo1;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int s0, s1;
        tbl[0] = '{3, -4, 1, 18, 40'hFF_FFFF_FFF4, 32'hFFFF_FFF4, 1, 1'b0};
        tbl[1] = '{100, 200, 0, 5, 40'h0, 32'h0, 0, 1'b0};
        tbl[2] = '{-50, 7, 0, 3, 40'h0, 32'h0, 0, 1'b0};
        tbl[3] = '{1000, 1000, 1, 6, 40'h00_000F_8F02, 32'h000F_8F02, 3, 1'b0};
        tbl[4] = '{32767, 32767, 0, 4, 40'h0, 32'h0, 0, 1'b0};
        tbl[5] = '{32767, 32767, 0, 2, 40'h0, 32'h0, 0, 1'b0};
        tbl[6] = '{32767, 32767, 1, 7, 40'h00_BFFD_0003, 32'hBFFD_0003, 3, 1'b1};
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {ir, ms, av, ov, er, cnt, ad0[15:0], ad1[15:0]}, {2'b11, 8'b0, 48'b0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        s0 = starts[0]; s1 = starts[1];
        for (int r = 0; r < 7; r++) begin
            send(tbl[r].a, tbl[r].b, tbl[r].last, tbl[r].lat);
            if (tbl[r].last)
                get_result($sformatf("vec%0d", r), r == 0 ? 10 : 2, tbl[r].e0, tbl[r].e1, tbl[r].ec,
                           1'b0, tbl[r].eo1, 1'b0);
        end
        chk("start_pulses", 64'({8'(starts[0] - s0), 8'(starts[1] - s1)}), 64'({8'd7, 8'd7}));

        // reset during WAIT abandons the pair and the partial sum
        send(5, 6, 0, 4);
        send(7, 8, 1, 30);
        repeat (10) @(posedge clk);
        #1;
        chk("waiting", 64'({ir, ms, av}), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset", {ir, ms, av, ov, er, cnt, ad0[15:0], ad1[15:0]}, {2'b11, 8'b0, 48'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        send(2, 3, 1, 2);
        get_result("after_reset", 1, 40'd6, 32'd6, 1, 1'b0, 1'b0, 1'b0);

        // multiplier that never finishes
        stuck = 2'b11;
        send(9, 9, 1, 5);
`ifdef BOOTH_MAC_TIMEOUT_EN
        begin
            int n = 0;
            while (!av[0] && n < 300) begin @(posedge clk); #1; n++; end
            chk("timeout_cycles", 64'(n), 64'(65));
            get_result("timeout", 1, 40'd0, 32'd0, 0, 1'b0, 1'b0, 1'b1);
        end
`else
        repeat (200) @(posedge clk);
        #1;
        chk("no_timeout", 64'({av, ir, ms, er}), 64'(0));
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif
        stuck = 2'b00;
        model_clear();

        // randomized accumulations against the model
        for (int t = 0; t < 60; t++) begin
            int a, b;
            bit last;
            a = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 32767 : -32768) : int'($signed(16'($urandom)));
            b = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 32767 : -32768) : int'($signed(16'($urandom)));
            last = (t == 59) || ($urandom_range(0, 3) == 0);
            send(a, b, last, $urandom_range(2, 9));
            if (last)
                get_result("rnd", $urandom_range(0, 3), 40'(tr(macc[0], 40)), 32'(tr(macc[1], 32)),
                           mcnt, movf[0], movf[1], 1'b0);
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", pass_n, tot_n);
        $fatal(1);
    end
endmodule
